// File: rtl/instruction_decoder_pkg.sv
// ---------------------------------------------------------------------------
// instruction_decoder_pkg
//  Shared definitions for the 8-bit instruction decoder: opcode prefixes,
//  instruction field bit positions, the NOP encoding, register index names
//  and a helper that classifies an instruction word by its opcode prefix.
// ---------------------------------------------------------------------------
package instruction_decoder_pkg;

    // Opcode prefixes, compared against the top bits of the instruction.
    localparam logic       OP_LDI = 1'b0;      // 0ddd_iiii
    localparam logic [1:0] OP_MOV = 2'b10;     // 10dd_dsss
    localparam logic [2:0] OP_ALU = 3'b110;    // 110x_ffff
    localparam logic [3:0] OP_JMP = 4'b1110;   // 1110_aaaa
    localparam logic [3:0] OP_JNZ = 4'b1111;   // 1111_aaaa

    // Field bit positions.
    localparam int LDI_DST_HI = 6;
    localparam int LDI_DST_LO = 4;
    localparam int MOV_DST_HI = 5;
    localparam int MOV_DST_LO = 3;
    localparam int MOV_SRC_HI = 2;
    localparam int MOV_SRC_LO = 0;
    localparam int NIB_HI     = 3;             // imm / alu_func / jmp_addr
    localparam int NIB_LO     = 0;

    // MOV x0,x0: destination equals source, so it decodes to no action at all.
    localparam logic [7:0] NOP_INSTR = 8'h80;

    // Register indices used by the datapath.
    localparam logic [2:0] REG_X0 = 3'd0;
    localparam logic [2:0] REG_X1 = 3'd1;
    localparam logic [2:0] REG_Y0 = 3'd2;
    localparam logic [2:0] REG_Y1 = 3'd3;
    localparam logic [2:0] REG_R  = 3'd4;
    localparam logic [2:0] REG_M  = 3'd5;
    localparam logic [2:0] REG_I  = 3'd6;
    localparam logic [2:0] REG_O  = 3'd7;

    typedef enum logic [2:0] {
        CLS_LDI,
        CLS_MOV,
        CLS_ALU,
        CLS_JMP,
        CLS_JNZ
    } instr_class_e;

    // Prefix match, checked from shortest to longest prefix.
    function automatic instr_class_e classify(input logic [7:0] instr);
        if (instr[7] == OP_LDI)
            return CLS_LDI;
        else if (instr[7:6] == OP_MOV)
            return CLS_MOV;
        else if (instr[7:5] == OP_ALU)
            return CLS_ALU;
        else if (instr[7:4] == OP_JMP)
            return CLS_JMP;
        else
            return CLS_JNZ;
    endfunction

endpackage

// File: rtl/instruction_decoder_reset_holdoff.sv
// ---------------------------------------------------------------------------
// instruction_decoder_reset_holdoff
//  Marks data from a synchronous RAM as invalid while reset is held and for
//  CYC cycles after it is released, covering the read latency of the first
//  post-reset fetch.
//
//  Ports:
//   clk         in   rising-edge clock
//   sync_reset  in   synchronous reset, active-high
//   valid       out  1 when the consumer may use the RAM read data
// ---------------------------------------------------------------------------
module instruction_decoder_reset_holdoff #(
    parameter int unsigned CYC = 1
) (
    input  logic clk,
    input  logic sync_reset,
    output logic valid
);

    localparam int unsigned CW = (CYC < 1) ? 1 : $clog2(CYC + 1);

    logic [CW-1:0] nop_cnt;

    always_ff @(posedge clk) begin
        if (sync_reset)
            nop_cnt <= CW'(CYC);
        else if (nop_cnt != '0)
            nop_cnt <= nop_cnt - 1'b1;
    end

    // Reset itself invalidates the data combinationally, so outputs go to NOP
    // in the very cycle reset is asserted.
    assign valid = !sync_reset && (nop_cnt == '0);

endmodule

// File: rtl/instruction_decoder.sv
// ---------------------------------------------------------------------------
// instruction_decoder
//  Decodes the instruction word returned by program memory into sequencer
//  jump requests, datapath register enables / source selects / immediate,
//  and ALU control. Holds the zero flag that the sequencer uses for JNZ.
//
//  Ports:
//   clk, sync_reset   clock and synchronous active-high reset
//   pm_data   in   instruction word (program memory read data)
//   alu_zero  in   ALU result is zero for the current ALU instruction
//   jmp       out  unconditional jump request
//   jmp_nz    out  conditional jump request
//   jmp_addr  out  jump page
//   dont_jmp  out  registered zero flag (1 = last ALU result was zero)
//   reg_en    out  one-hot register load enable
//   src_sel   out  MOV source register
//   imm       out  LDI immediate
//   imm_sel   out  1 = write data from imm, 0 = from src_sel
//   alu_en    out  ALU executes this cycle
//   alu_func  out  ALU operation code
// ---------------------------------------------------------------------------
module instruction_decoder
    import instruction_decoder_pkg::*;
#(
    parameter int IW          = 8,
    parameter int NREG        = 8,
    parameter int RST_NOP_CYC = 1
) (
    input  logic            clk,
    input  logic            sync_reset,
    input  logic [IW-1:0]   pm_data,
    input  logic            alu_zero,
    output logic            jmp,
    output logic            jmp_nz,
    output logic [3:0]      jmp_addr,
    output logic            dont_jmp,
    output logic [NREG-1:0] reg_en,
    output logic [2:0]      src_sel,
    output logic [3:0]      imm,
    output logic            imm_sel,
    output logic            alu_en,
    output logic [3:0]      alu_func
);

    logic         valid;
    logic [IW-1:0] instr;
    instr_class_e cls;
    logic         z;

    instruction_decoder_reset_holdoff #(
        .CYC(RST_NOP_CYC)
    ) u_holdoff (
        .clk       (clk),
        .sync_reset(sync_reset),
        .valid     (valid)
    );

    // Invalid read data is replaced by a NOP word, so the decode below never
    // needs to look at valid itself.
    assign instr = valid ? pm_data : IW'(NOP_INSTR);
    assign cls   = classify(instr[7:0]);

    always_comb begin
        jmp      = 1'b0;
        jmp_nz   = 1'b0;
        jmp_addr = 4'h0;
        reg_en   = '0;
        src_sel  = 3'd0;
        imm      = 4'h0;
        imm_sel  = 1'b0;
        alu_en   = 1'b0;
        alu_func = 4'h0;
        case (cls)
            CLS_LDI: begin
                reg_en  = NREG'(1) << instr[LDI_DST_HI:LDI_DST_LO];
                imm     = instr[NIB_HI:NIB_LO];
                imm_sel = 1'b1;
            end
            CLS_MOV: begin
                // A register moved onto itself is a NOP, not a reload.
                if (instr[MOV_DST_HI:MOV_DST_LO] != instr[MOV_SRC_HI:MOV_SRC_LO]) begin
                    reg_en  = NREG'(1) << instr[MOV_DST_HI:MOV_DST_LO];
                    src_sel = instr[MOV_SRC_HI:MOV_SRC_LO];
                end
            end
            CLS_ALU: begin
                alu_en   = 1'b1;
                alu_func = instr[NIB_HI:NIB_LO];
            end
            CLS_JMP: begin
                jmp      = 1'b1;
                jmp_addr = instr[NIB_HI:NIB_LO];
            end
            CLS_JNZ: begin
                jmp_nz   = 1'b1;
                jmp_addr = instr[NIB_HI:NIB_LO];
            end
            default: ;
        endcase
    end

    // alu_en is already forced low for invalid cycles, including the reset
    // cycle, so an ALU op interrupted by reset never touches the flag.
    always_ff @(posedge clk) begin
        if (sync_reset)
            z <= 1'b1;
        else if (alu_en)
            z <= alu_zero;
    end

    assign dont_jmp = z;

endmodule

// File: tb/tb_instruction_decoder.sv
// Self-checking bench for instruction_decoder: directed vectors with literal
// expectations, plus a reference model compared against the DUT every cycle.
module tb_instruction_decoder;
    import instruction_decoder_pkg::*;

    localparam int RST_NOP_CYC = 1;

    logic       clk;
    logic       sync_reset;
    logic [7:0] pm_data;
    logic       alu_zero;
    logic       jmp, jmp_nz, dont_jmp, imm_sel, alu_en;
    logic [3:0] jmp_addr, imm, alu_func;
    logic [7:0] reg_en;
    logic [2:0] src_sel;

    int errors = 0;
    int checks = 0;

    instruction_decoder #(
        .IW(8), .NREG(8), .RST_NOP_CYC(RST_NOP_CYC)
    ) dut (
        .clk       (clk),
        .sync_reset(sync_reset),
        .pm_data   (pm_data),
        .alu_zero  (alu_zero),
        .jmp       (jmp),
        .jmp_nz    (jmp_nz),
        .jmp_addr  (jmp_addr),
        .dont_jmp  (dont_jmp),
        .reg_en    (reg_en),
        .src_sel   (src_sel),
        .imm       (imm),
        .imm_sel   (imm_sel),
        .alu_en    (alu_en),
        .alu_func  (alu_func)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [7:0] reg_en;
        logic [2:0] src_sel;
        logic [3:0] imm;
        logic       imm_sel;
        logic       alu_en;
        logic [3:0] alu_func;
        logic       jmp;
        logic       jmp_nz;
        logic [3:0] jmp_addr;
    } dec_t;

    // Reference decode written from the opcode table using numeric ranges.
    function automatic dec_t model_decode(input int code, input bit ok);
        dec_t e;
        int d, s;
        e = '0;
        if (!ok) return e;
        if (code < 128) begin
            e.reg_en  = 8'(1 << ((code / 16) % 8));
            e.imm     = 4'(code % 16);
            e.imm_sel = 1'b1;
        end else if (code < 192) begin
            d = (code / 8) % 8;
            s = code % 8;
            if (d != s) begin
                e.reg_en  = 8'(1 << d);
                e.src_sel = 3'(s);
            end
        end else if (code < 224) begin
            e.alu_en   = 1'b1;
            e.alu_func = 4'(code % 16);
        end else if (code < 240) begin
            e.jmp      = 1'b1;
            e.jmp_addr = 4'(code % 16);
        end else begin
            e.jmp_nz   = 1'b1;
            e.jmp_addr = 4'(code % 16);
        end
        return e;
    endfunction

    // Model state: cycles since reset release and the expected zero flag.
    int  since_rel = 0;
    bit  model_z   = 1'b1;
    bit  check_en  = 1'b0;

    function automatic bit model_valid();
        return !sync_reset && (since_rel >= RST_NOP_CYC);
    endfunction

    always @(posedge clk) begin
        if (sync_reset) begin
            since_rel = 0;
            model_z   = 1'b1;
        end else begin
            if (model_valid() && pm_data >= 8'd192 && pm_data < 8'd224)
                model_z = alu_zero;
            if (since_rel < 1000) since_rel++;
        end
        check_en = 1'b1;
    end

    // Compare process: whole decode bundle, flag and mutual exclusion each cycle.
    always @(negedge clk) begin
        dec_t act, exp_d;
        if (check_en) begin
            act   = '{reg_en, src_sel, imm, imm_sel, alu_en, alu_func, jmp, jmp_nz, jmp_addr};
            exp_d = model_decode(int'(pm_data), model_valid());
            checks++;
            if (act !== exp_d) begin
                errors++;
                $display("[TB] FAIL decode pm_data=%h: actual=%h required=%h", pm_data, act, exp_d);
            end
            checks++;
            if (dont_jmp !== model_z) begin
                errors++;
                $display("[TB] FAIL zero_flag pm_data=%h: actual=%b required=%b", pm_data, dont_jmp, model_z);
            end
            checks++;
            if ($countones({reg_en, alu_en, jmp, jmp_nz}) > 1) begin
                errors++;
                $display("[TB] FAIL one_hot pm_data=%h: actual=%b required=at most one bit", pm_data,
                         {reg_en, alu_en, jmp, jmp_nz});
            end
        end
    end

    // Drive one cycle of inputs just after the rising edge, return at the falling edge.
    task automatic applyStimulus(input logic rst, input logic [7:0] data, input logic az);
        @(posedge clk);
        #1;
        sync_reset = rst;
        pm_data    = data;
        alu_zero   = az;
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
        end
    endtask

    initial begin
        sync_reset = 1'b1;
        pm_data    = 8'hE5;
        alu_zero   = 1'b0;

        $display("[TB] reset and holdoff");
        applyStimulus(1'b1, 8'hE5, 1'b0);
        applyStimulus(1'b1, 8'hE5, 1'b0);
        checkOutput("rst_jmp", 32'(jmp), 32'h0);
        checkOutput("rst_dont_jmp", 32'(dont_jmp), 32'h1);
        checkOutput("rst_reg_en", 32'(reg_en), 32'h0);
        applyStimulus(1'b0, 8'hE5, 1'b0);
        checkOutput("holdoff_jmp", 32'(jmp), 32'h0);
        checkOutput("holdoff_jmp_addr", 32'(jmp_addr), 32'h0);
        applyStimulus(1'b0, 8'hE5, 1'b0);
        checkOutput("first_jmp", 32'(jmp), 32'h1);
        checkOutput("first_jmp_addr", 32'(jmp_addr), 32'h5);

        $display("[TB] LDI / MOV");
        applyStimulus(1'b0, 8'h3A, 1'b0);
        checkOutput("ldi_reg_en", 32'(reg_en), 32'(8'b1 << REG_Y1));
        checkOutput("ldi_imm", 32'(imm), 32'hA);
        checkOutput("ldi_imm_sel", 32'(imm_sel), 32'h1);
        applyStimulus(1'b0, 8'h8A, 1'b0);
        checkOutput("mov_reg_en", 32'(reg_en), 32'h02);
        checkOutput("mov_src_sel", 32'(src_sel), 32'h2);
        checkOutput("mov_imm_sel", 32'(imm_sel), 32'h0);
        applyStimulus(1'b0, 8'h89, 1'b0);
        checkOutput("mov_self_enables", 32'({reg_en, alu_en, jmp, jmp_nz}), 32'h0);

        $display("[TB] zero flag");
        applyStimulus(1'b0, 8'hC3, 1'b0);
        checkOutput("alu_en", 32'(alu_en), 32'h1);
        checkOutput("alu_func", 32'(alu_func), 32'h3);
        checkOutput("alu_cycle_flag", 32'(dont_jmp), 32'h1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("flag_cleared", 32'(dont_jmp), 32'h0);
        applyStimulus(1'b0, 8'hD3, 1'b1);
        checkOutput("alu_bit4_func", 32'(alu_func), 32'h3);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("flag_set", 32'(dont_jmp), 32'h1);

        $display("[TB] JNZ ordering");
        applyStimulus(1'b0, 8'hC5, 1'b0);
        applyStimulus(1'b0, 8'h3A, 1'b1);
        checkOutput("ldi_keeps_flag", 32'(dont_jmp), 32'h0);
        applyStimulus(1'b0, 8'hE3, 1'b1);
        checkOutput("jmp_keeps_flag", 32'(dont_jmp), 32'h0);
        applyStimulus(1'b0, 8'hF7, 1'b1);
        checkOutput("jnz_req", 32'(jmp_nz), 32'h1);
        checkOutput("jnz_addr", 32'(jmp_addr), 32'h7);
        checkOutput("jnz_flag", 32'(dont_jmp), 32'h0);

        $display("[TB] reset mid-run");
        applyStimulus(1'b1, 8'hC0, 1'b0);
        checkOutput("midrst_alu_en", 32'(alu_en), 32'h0);
        applyStimulus(1'b0, 8'hC0, 1'b0);
        checkOutput("midrst_flag", 32'(dont_jmp), 32'h1);
        checkOutput("midrst_holdoff", 32'(alu_en), 32'h0);
        applyStimulus(1'b0, 8'hC0, 1'b0);
        checkOutput("midrst_resume", 32'(alu_en), 32'h1);
        applyStimulus(1'b0, 8'hE5, 1'b0);
        checkOutput("midrst_flag_update", 32'(dont_jmp), 32'h0);

        $display("[TB] opcode sweep");
        for (int i = 0; i < 256; i++)
            applyStimulus(1'b0, 8'(i), 1'((i % 3) == 0));

        applyStimulus(1'b0, 8'h80, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
